ej32_div_seq: RTL and testbench

//   Sequential signed 32-bit integer divider serving the data processor's idiv/irem path.

---
 rtl/ej32_div_seq.sv | 126 ++++++++++++
 tb/tb_ej32_div_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ej32_div_seq.sv
// rtl/ej32_div_seq.sv - sequential signed divider, restoring radix-2, Java semantics
// Reset doubles as start: the first edge with rst low loads the operands.
module ej32_div_seq #(
   parameter int DSZ = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [DSZ-1:0] x,
   input  logic [DSZ-1:0] y,
   output logic           bsy,
   output logic           z,
   output logic [DSZ-1:0] q,
   output logic [DSZ-1:0] r
);

   localparam int CW = $clog2(DSZ);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [DSZ-1:0] rem_q, rem_d;
   logic [DSZ-1:0] quo_q, quo_d;
   logic [DSZ-1:0] ay_q, ay_d;
   logic           sq_q, sq_d;
   logic           sr_q, sr_d;
   logic [DSZ-1:0] q_q, q_d;
   logic [DSZ-1:0] r_q, r_d;
   logic           z_q, z_d;

   logic [DSZ-1:0] ax;
   logic [DSZ:0]   rem_sh;
   logic [DSZ+1:0] trial;

   // Magnitudes are unsigned, so |0x80000000| stays representable.
   assign ax     = x[DSZ-1] ? (~x + 1'b1) : x;
   assign rem_sh = {rem_q, quo_q[DSZ-1]};
   assign trial  = {1'b0, rem_sh} - {2'b00, ay_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      ay_d    = ay_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      q_d     = q_q;
      r_d     = r_q;
      z_d     = z_q;
      case (state_q)
         S_LOAD: begin
            ay_d  = y[DSZ-1] ? (~y + 1'b1) : y;
            sq_d  = x[DSZ-1] ^ y[DSZ-1];
            sr_d  = x[DSZ-1];
            rem_d = '0;
            quo_d = ax;
            cnt_d = CW'(DSZ - 1);
            if (y == '0) begin
               z_d     = 1'b1;
               q_d     = '0;
               r_d     = x;
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Negative trial (borrow out of the top bit) restores the shifted remainder.
            if (!trial[DSZ+1]) begin
               rem_d = trial[DSZ-1:0];
               quo_d = {quo_q[DSZ-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[DSZ-1:0];
               quo_d = {quo_q[DSZ-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = S_FIX;
         end
         S_FIX: begin
            q_d     = sq_q ? (~quo_q + 1'b1) : quo_q;
            r_d     = sr_q ? (~rem_q + 1'b1) : rem_q;
            z_d     = 1'b0;
            state_d = S_DONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOAD;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         ay_q    <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         ay_q    <= ay_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         q_q     <= q_d;
         r_q     <= r_d;
         z_q     <= z_d;
      end
   end

   assign bsy = (state_q != S_DONE);
   assign z   = z_q;
   assign q   = q_q;
   assign r   = r_q;

endmodule

// File: tb/tb_ej32_div_seq.sv
// tb/tb_ej32_div_seq.sv - scoreboard bench for ej32_div_seq
module tb_ej32_div_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] x   = '0;
   logic [31:0] y   = '0;
   logic        bsy;
   logic        z;
   logic [31:0] q;
   logic [31:0] r;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      int          lat;
   } exp_t;

   exp_t sb[$];

   ej32_div_seq #(.DSZ(32)) dut (
      .clk(clk), .rst(rst), .x(x), .y(y),
      .bsy(bsy), .z(z), .q(q), .r(r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic exp_t ref_div(input logic [31:0] xi, input logic [31:0] yi);
      exp_t e;
      int   a, b;
      a = xi;
      b = yi;
      if (yi == 32'h0) begin
         e.q = 32'h0; e.r = xi; e.z = 1'b1; e.lat = 1;
      end else if (xi == 32'h8000_0000 && yi == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000; e.r = 32'h0; e.z = 1'b0; e.lat = 34;
      end else begin
         e.q = a / b; e.r = a % b; e.z = 1'b0; e.lat = 34;
      end
      return e;
   endfunction

   // Reset, release with operands, optionally scramble inputs after LOAD, then score.
   task automatic do_div(input string tag, input logic [31:0] xi, input logic [31:0] yi,
                         input bit scramble, input bit verbose);
      exp_t e;
      int   edges;
      @(negedge clk);
      rst = 1'b1;
      x   = xi;
      y   = yi;
      @(negedge clk);
      if (verbose) chk({tag, "_rst_bsy"}, 32'(bsy), 32'd1);
      sb.push_back(ref_div(xi, yi));
      rst   = 1'b0;
      edges = 0;
      while (edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (scramble) begin
            x = $urandom;
            y = $urandom;
         end
         if (!bsy) break;
      end
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(edges), 32'(e.lat));
      chk({tag, "_q"}, q, e.q);
      chk({tag, "_r"}, r, e.r);
      chk({tag, "_z"}, 32'(z), 32'(e.z));
      if (verbose) begin
         repeat (5) @(negedge clk);
         chk({tag, "_hold_bsy"}, 32'(bsy), 32'd0);
         chk({tag, "_hold_q"}, q, e.q);
         chk({tag, "_hold_r"}, r, e.r);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_bsy", 32'(bsy), 32'd1);
      chk("reset_q", q, 32'h0);
      chk("reset_r", r, 32'h0);
      chk("reset_z", 32'(z), 32'd0);

      do_div("pos_pos", 32'd100, 32'd7, 1'b0, 1'b1);
      chk("pos_pos_q_const", q, 32'd14);
      chk("pos_pos_r_const", r, 32'd2);
      do_div("neg_pos", 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
      chk("neg_pos_q_const", q, 32'hFFFF_FFF2);
      chk("neg_pos_r_const", r, 32'hFFFF_FFFE);
      do_div("pos_neg", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0);
      chk("pos_neg_q_const", q, 32'hFFFF_FFF2);
      do_div("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
      do_div("min_p1", 32'h8000_0000, 32'd1, 1'b0, 1'b0);
      do_div("divzero", 32'd5, 32'd0, 1'b0, 1'b1);
      chk("divzero_r_const", r, 32'd5);

      // Abort mid-run: reset wins, results cleared, busy stays up.
      @(negedge clk);
      rst = 1'b1;
      x   = 32'd1000;
      y   = 32'd3;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_bsy", 32'(bsy), 32'd1);
      chk("abort_q", q, 32'h0);
      chk("abort_r", r, 32'h0);
      do_div("after_abort", 32'hFFFF_FFF7, 32'd4, 1'b0, 1'b1);
      chk("after_abort_q_const", q, 32'hFFFF_FFFE);
      chk("after_abort_r_const", r, 32'hFFFF_FFFF);

      for (int i = 0; i < 1500; i++) begin
         logic [31:0] rx, ry;
         rx = $urandom;
         ry = $urandom;
         case (i % 4)
            1: ry = 32'($urandom_range(1, 20));
            2: ry = -32'($urandom_range(1, 20));
            3: rx = 32'($urandom_range(0, 50));
            default: ;
         endcase
         if (ry == 32'h0) ry = 32'd1;
         do_div("rand", rx, ry, 1'b1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
